ascon_aead128a_iter: RTL and testbench

//  Iterative, clocked Ascon-128a AEAD core: one key/nonce/AD block/data block per job, encrypt or decrypt.
//  Re-uses one UNROLL-round datapath for all 40 rounds instead of fully unrolled permutations.

---
 rtl/ascon_aead128a_iter_if.sv | 28 ++
 rtl/ascon_aead128a_iter.sv | 166 ++++++++++++++++
 tb/tb_ascon_aead128a_iter.sv | 302 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ascon_aead128a_iter_if.sv
// Job request / result handshake bundle for the iterative Ascon-128a AEAD core.
// The master side issues jobs and consumes results; the core is the slave.
interface ascon_aead128a_iter_if;
    logic         in_valid;
    logic         in_ready;
    logic         mode;
    logic         ad_en;
    logic [127:0] key;
    logic [127:0] nonce;
    logic [127:0] ad;
    logic [127:0] din;
    logic [127:0] tag_in;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] dout;
    logic [127:0] tag;
    logic         tag_ok;

    modport master (
        output in_valid, mode, ad_en, key, nonce, ad, din, tag_in, out_ready,
        input  in_ready, out_valid, dout, tag, tag_ok
    );

    modport slave (
        input  in_valid, mode, ad_en, key, nonce, ad, din, tag_in, out_ready,
        output in_ready, out_valid, dout, tag, tag_ok
    );
endinterface

// File: rtl/ascon_aead128a_iter.sv
// Iterative Ascon-128a AEAD core: one shared UNROLL-round datapath runs all 40 rounds
// of a job (INIT 12, AD 8, DATA 8, FINAL 12), with phase XORs folded into the last round.
module ascon_aead128a_iter #(
    parameter int UNROLL = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    ascon_aead128a_iter_if.slave  bus
);
    if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4) begin : g_bad_unroll
        $error("ascon_aead128a_iter: UNROLL must be 1, 2 or 4");
    end

    localparam logic [63:0] IV = 64'h80800c0800000000;

    typedef enum logic [2:0] {S_IDLE, S_INIT, S_AD, S_DATA, S_FINAL, S_DONE} state_t;

    function automatic logic [63:0] rotr(input logic [63:0] x, input int n);
        return (x >> n) | (x << (64 - n));
    endfunction

    function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] r);
        logic [63:0] x0, x1, x2, x3, x4, t0, t1, t2, t3, t4;
        {x0, x1, x2, x3, x4} = s;
        x2 = x2 ^ {56'd0, 4'hF - r, r};
        x0 ^= x4;  x4 ^= x3;  x2 ^= x1;
        t0 = ~x0 & x1;  t1 = ~x1 & x2;  t2 = ~x2 & x3;  t3 = ~x3 & x4;  t4 = ~x4 & x0;
        x0 ^= t1;  x1 ^= t2;  x2 ^= t3;  x3 ^= t4;  x4 ^= t0;
        x1 ^= x0;  x0 ^= x4;  x3 ^= x2;  x2 = ~x2;
        x0 ^= rotr(x0, 19) ^ rotr(x0, 28);
        x1 ^= rotr(x1, 61) ^ rotr(x1, 39);
        x2 ^= rotr(x2, 1)  ^ rotr(x2, 6);
        x3 ^= rotr(x3, 10) ^ rotr(x3, 17);
        x4 ^= rotr(x4, 7)  ^ rotr(x4, 41);
        return {x0, x1, x2, x3, x4};
    endfunction

    state_t       r_state;
    logic [3:0]   r_cnt;
    logic [319:0] r_x;
    logic         r_mode;
    logic         r_ad_en;
    logic [127:0] r_key;
    logic [127:0] r_ad;
    logic [127:0] r_din;
    logic [127:0] r_tag_in;
    logic [127:0] r_out_data;
    logic         r_in_ready;
    logic         r_out_valid;
    logic [127:0] r_dout;
    logic [127:0] r_tag;
    logic         r_tag_ok;

    logic [3:0]   w_base;
    logic [3:0]   w_len;
    logic         w_last;
    logic         w_absorb;
    logic [319:0] w_perm;
    logic [319:0] w_next;
    logic [127:0] w_odata;
    logic [127:0] w_cdata;
    logic [127:0] w_tag;
    logic         w_match;

    // Lane layout in r_x: x0=[319:256] x1=[255:192] x2=[191:128] x3=[127:64] x4=[63:0]
    always_comb begin
        w_base   = (r_state == S_AD || r_state == S_DATA) ? 4'd4 : 4'd0;
        w_len    = (r_state == S_AD || r_state == S_DATA) ? 4'd8 : 4'd12;
        w_last   = (r_cnt + 4'(UNROLL)) == w_len;
        w_perm   = r_x;
        for (int i = 0; i < UNROLL; i++) begin
            w_perm = ascon_round(w_perm, w_base + r_cnt + 4'(i));
        end
        w_next   = w_perm;
        w_absorb = 1'b0;
        case (r_state)
            S_INIT: begin
                w_next[127:0] ^= r_key;
                if (r_ad_en) begin
                    w_next[319:256] ^= r_ad[63:0];
                    w_next[255:192] ^= r_ad[127:64];
                end else begin
                    w_absorb = 1'b1;
                end
            end
            S_AD:    w_absorb = 1'b1;
            S_DATA:  w_next[191:64] ^= r_key;
            default: ;
        endcase
        w_odata = w_next[319:192] ^ r_din;
        w_cdata = r_mode ? r_din : w_odata;
        if (w_absorb) begin
            w_next[0]       ^= 1'b1;
            w_next[319:192]  = {w_cdata[63:0], w_cdata[127:64]};
        end
    end

    assign w_tag   = w_perm[127:0] ^ r_key;
    assign w_match = (w_tag == r_tag_in);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_dout      <= '0;
            r_tag       <= '0;
            r_tag_ok    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        r_mode     <= bus.mode;
                        r_ad_en    <= bus.ad_en;
                        r_key      <= bus.key;
                        r_ad       <= bus.ad;
                        r_din      <= bus.din;
                        r_tag_in   <= bus.tag_in;
                        r_x        <= {IV, bus.key, bus.nonce};
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_INIT;
                    end
                end
                S_INIT, S_AD, S_DATA, S_FINAL: begin
                    if (!w_last) begin
                        r_x   <= w_perm;
                        r_cnt <= r_cnt + 4'(UNROLL);
                    end else begin
                        r_x   <= w_next;
                        r_cnt <= '0;
                        if (w_absorb) r_out_data <= w_odata;
                        case (r_state)
                            S_INIT:  r_state <= r_ad_en ? S_AD : S_DATA;
                            S_AD:    r_state <= S_DATA;
                            S_DATA:  r_state <= S_FINAL;
                            default: begin
                                // Decrypted data is released only when the tag matches
                                r_tag       <= w_tag;
                                r_tag_ok    <= r_mode & w_match;
                                r_dout      <= (r_mode && !w_match) ? '0 : r_out_data;
                                r_out_valid <= 1'b1;
                                r_state     <= S_DONE;
                            end
                        endcase
                    end
                end
                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.dout      = r_dout;
    assign bus.tag       = r_tag;
    assign bus.tag_ok    = r_tag_ok;
endmodule

// File: tb/tb_ascon_aead128a_iter.sv
// Scoreboard bench for ascon_aead128a_iter: a table-driven S-box reference model predicts
// each job; a negedge monitor pops and compares results as the core presents them.
module tb_ascon_aead128a_iter;
    parameter int UNROLL = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ascon_aead128a_iter_if bus();
    ascon_aead128a_iter #(.UNROLL(UNROLL)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef logic [4:0][63:0] st_t;
    typedef struct packed {
        logic [127:0] dout;
        logic [127:0] tag;
        logic         ok;
        int           lat;
        int           acc;
    } exp_t;

    localparam logic [63:0] IV = 64'h80800c0800000000;
    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};
    localparam int RA [5] = '{19, 61, 1, 10, 7};
    localparam int RB [5] = '{28, 39, 6, 17, 41};

    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    exp_t q[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] rotr64(input logic [63:0] x, input int n);
        logic [127:0] d;
        d = {x, x} >> n;
        return d[63:0];
    endfunction

    // Lane i of s is x_i; the S-box is applied column by column with x0 as the MSB.
    function automatic st_t permute(input st_t s, input int nr);
        logic [4:0] col;
        logic [7:0] c;
        for (int r = 12 - nr; r < 12; r++) begin
            c = 8'((15 - r) * 16 + r);
            s[2][7:0] = s[2][7:0] ^ c;
            for (int b = 0; b < 64; b++) begin
                col = SBOX[{s[0][b], s[1][b], s[2][b], s[3][b], s[4][b]}];
                s[0][b] = col[4];
                s[1][b] = col[3];
                s[2][b] = col[2];
                s[3][b] = col[1];
                s[4][b] = col[0];
            end
            for (int i = 0; i < 5; i++) s[i] = s[i] ^ rotr64(s[i], RA[i]) ^ rotr64(s[i], RB[i]);
        end
        return s;
    endfunction

    function automatic exp_t model_job(input logic m, input logic a_en, input logic [127:0] k,
                                       input logic [127:0] n, input logic [127:0] a,
                                       input logic [127:0] d, input logic [127:0] ti);
        st_t          s;
        exp_t         e;
        logic [127:0] od, c, t;
        s[0] = IV;  s[1] = k[127:64];  s[2] = k[63:0];  s[3] = n[127:64];  s[4] = n[63:0];
        s = permute(s, 12);
        s[3] ^= k[127:64];
        s[4] ^= k[63:0];
        if (a_en) begin
            s[0] ^= a[63:0];
            s[1] ^= a[127:64];
            s = permute(s, 8);
        end
        s[4][0] ^= 1'b1;
        od = {s[0], s[1]} ^ d;
        c  = m ? d : od;
        s[0] = c[63:0];
        s[1] = c[127:64];
        s = permute(s, 8);
        s[2] ^= k[127:64];
        s[3] ^= k[63:0];
        s = permute(s, 12);
        t = {s[3], s[4]} ^ k;
        e.tag  = t;
        e.ok   = m && (t == ti);
        e.dout = (m && (t != ti)) ? '0 : od;
        e.lat  = (a_en ? 40 : 32) / UNROLL;
        e.acc  = 0;
        return e;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h", name, act, req);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: bounded wait expired at cycle %0d", name, cyc);
    endtask

    task automatic issue(input logic m, input logic a_en, input logic [127:0] k,
                         input logic [127:0] n, input logic [127:0] a, input logic [127:0] d,
                         input logic [127:0] ti, input bit push, input bit keep,
                         output int acc, output exp_t e);
        int waited;
        e = model_job(m, a_en, k, n, a, d, ti);
        @(negedge clk);
        bus.mode = m;  bus.ad_en = a_en;  bus.key = k;  bus.nonce = n;
        bus.ad = a;    bus.din = d;       bus.tag_in = ti;
        bus.in_valid = 1'b1;
        waited = 0;
        while (!bus.in_ready && waited < 500) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.in_ready) begin
            fail_now("accept_timeout");
            bus.in_valid = 1'b0;
            acc = -1;
            return;
        end
        acc   = cyc + 1;
        e.acc = acc;
        if (push) q.push_back(e);
        if (!keep) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            bus.mode = 1'($urandom_range(0, 1));  bus.ad_en = 1'($urandom_range(0, 1));
            bus.key = rnd128();  bus.nonce = rnd128();  bus.ad = rnd128();
            bus.din = rnd128();  bus.tag_in = rnd128();
        end
    endtask

    task automatic drain();
        int waited;
        waited = 0;
        while (q.size() != 0 && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        if (q.size() != 0) begin
            fail_now("drain_timeout");
            q.delete();
        end
        repeat (2) @(negedge clk);
    endtask

    // Result monitor
    int   rise_cyc = 0;
    int   last_hs  = -10;
    logic prev_v   = 1'b0;
    exp_t me;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_v = 1'b0;
            end else begin
                if (bus.out_valid && !prev_v) rise_cyc = cyc;
                prev_v = bus.out_valid;
                if (bus.out_valid && bus.out_ready) begin
                    last_hs = cyc + 1;
                    if (q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_output: actual dout %h required none", bus.dout);
                    end else begin
                        me = q.pop_front();
                        chk("dout", bus.dout, me.dout);
                        chk("tag", bus.tag, me.tag);
                        chk("tag_ok", 128'(bus.tag_ok), 128'(me.ok));
                        chk("latency", 128'(rise_cyc - me.acc), 128'(me.lat));
                    end
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] k, n, a, p, ti;
        logic         ae;
        int           acc, acc2, cnt_hi, L;
        exp_t         e1, e2, ee;

        bus.in_valid = 1'b0;  bus.mode = 1'b0;  bus.ad_en = 1'b0;
        bus.key = '0;  bus.nonce = '0;  bus.ad = '0;  bus.din = '0;  bus.tag_in = '0;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
        chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
        chk("rst_dout", bus.dout, '0);
        chk("rst_tag", bus.tag, '0);
        chk("rst_tag_ok", 128'(bus.tag_ok), 128'(0));
        rst = 1'b0;

        // Known-input encrypt, then decrypt of its result with correct and corrupted tag
        k = 128'h000102030405060708090A0B0C0D0E0F;
        issue(1'b0, 1'b1, k, k, '0, '0, '0, 1'b1, 1'b0, acc, e1);
        drain();
        issue(1'b1, 1'b1, k, k, '0, e1.dout, e1.tag, 1'b1, 1'b0, acc, e2);
        drain();
        issue(1'b1, 1'b1, k, k, '0, e1.dout, e1.tag ^ 128'd1, 1'b1, 1'b0, acc, e2);
        drain();

        // Random jobs: encrypt, valid decrypt, forged decrypt; with and without AD
        for (int j = 0; j < 12; j++) begin
            k = rnd128();  n = rnd128();  a = rnd128();  p = rnd128();
            ae = 1'($urandom_range(0, 1));
            ee = model_job(1'b0, ae, k, n, a, p, '0);
            case ($urandom_range(0, 2))
                0:       issue(1'b0, ae, k, n, a, p, rnd128(), 1'b1, 1'b0, acc, e2);
                1:       issue(1'b1, ae, k, n, a, ee.dout, ee.tag, 1'b1, 1'b0, acc, e2);
                default: issue(1'b1, ae, k, n, a, ee.dout, rnd128(), 1'b1, 1'b0, acc, e2);
            endcase
            drain();
        end

        // Backpressure: result held for 5 cycles while a new request waits
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        issue(1'b0, 1'b1, rnd128(), rnd128(), rnd128(), rnd128(), '0, 1'b1, 1'b0, acc, e1);
        cnt_hi = 0;
        while (!bus.out_valid && cnt_hi < 200) begin
            @(negedge clk);
            cnt_hi++;
        end
        if (!bus.out_valid) fail_now("t4_wait_valid");
        fork
            issue(1'b1, 1'b0, rnd128(), rnd128(), rnd128(), rnd128(), rnd128(), 1'b1, 1'b0, acc2, e2);
            begin
                for (int s = 0; s < 5; s++) begin
                    if (s != 0) @(negedge clk);
                    chk("t4_hold_valid", 128'(bus.out_valid), 128'(1));
                    chk("t4_in_ready", 128'(bus.in_ready), 128'(0));
                    chk("t4_hold_dout", bus.dout, e1.dout);
                    chk("t4_hold_tag", bus.tag, e1.tag);
                end
                @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        chk("t4_accept_after_release", 128'(acc2), 128'(last_hs + 1));
        drain();

        // Reset during FINAL discards the job
        L = 40 / UNROLL;
        issue(1'b0, 1'b1, rnd128(), rnd128(), rnd128(), rnd128(), '0, 1'b0, 1'b0, acc, e1);
        while (cyc < acc + L - 2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("t5_in_ready", 128'(bus.in_ready), 128'(1));
        chk("t5_out_valid", 128'(bus.out_valid), 128'(0));
        chk("t5_dout", bus.dout, '0);
        chk("t5_tag", bus.tag, '0);
        chk("t5_tag_ok", 128'(bus.tag_ok), 128'(0));
        cnt_hi = 0;
        for (int s = 0; s < L + 5; s++) begin
            @(negedge clk);
            if (bus.out_valid) cnt_hi++;
        end
        chk("t5_no_output", 128'(cnt_hi), 128'(0));
        issue(1'b0, 1'b0, rnd128(), rnd128(), rnd128(), rnd128(), '0, 1'b1, 1'b0, acc, e1);
        drain();

        // Back-to-back jobs with in_valid held and out_ready tied high
        ti = '0;
        issue(1'b0, 1'b1, rnd128(), rnd128(), rnd128(), rnd128(), ti, 1'b1, 1'b1, acc, e1);
        for (int j = 0; j < 2; j++) begin
            issue(1'(j), 1'(1 - j), rnd128(), rnd128(), rnd128(), rnd128(), rnd128(),
                  1'b1, 1'b1, acc, e2);
            chk("t6_b2b_spacing", 128'(acc), 128'(last_hs + 1));
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
